mpa_road_arbiter: RTL and testbench

Merges the four MPA road streams (ports p0–p3, 30-bit words with data-valid) into one valid/ready output stream for the downstream road sink. Each port has a small FIFO, and a round-robin arbiter shares the single output between them. The block also sequences the end of a run: on `eor_in` it drains every buffer, then emits a one-cycle `eor_out`, so no road word is lost at a run boundary.

---
 rtl/mpa_road_pkg.sv | 13 +
 rtl/mpa_road_fifo.sv | 50 +++++
 rtl/mpa_road_arbiter.sv | 128 ++++++++++++
 tb/tb_mpa_road_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpa_road_pkg.sv
// Shared types and constants for the MPA road stream merger.
package mpa_road_pkg;
  localparam int ROAD_W  = 30;
  localparam int N_PORTS = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [1:0] port_idx_t;
endpackage

// File: rtl/mpa_road_fifo.sv
// Per-port synchronous FIFO with first-word-fall-through read data.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module mpa_road_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mpa_road_arbiter.sv
// Merges four road streams through per-port FIFOs and a round-robin output register,
// with end-of-run drain sequencing. Optional per-port word counters: MPA_ARB_STATS_EN.
module mpa_road_arbiter #(
  parameter int ROAD_W     = mpa_road_pkg::ROAD_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*ROAD_W-1:0] in_data,
  input  logic [3:0]          in_dv,
  input  logic                eor_in,
  output logic [ROAD_W-1:0]   out_data,
  output logic [1:0]          out_port,
  output logic                out_dv,
  input  logic                out_rdy,
  output logic                eor_out,
  output logic                busy,
  output logic [3:0]          ovf,
  output logic [3:0]          fifo_full
`ifdef MPA_ARB_STATS_EN
  ,
  output logic [4*16-1:0]     word_cnt
`endif
);
  import mpa_road_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [N_PORTS-1:0] empty;
  logic [N_PORTS-1:0] full;
  logic [N_PORTS-1:0] pop;
  logic [N_PORTS-1:0] drop;
  logic [ROAD_W-1:0]  dout  [N_PORTS];
  logic [CW-1:0]      count [N_PORTS];
  logic               load;
  logic               any_req;
  port_idx_t          grant;
  port_idx_t          idx;
  port_idx_t          rr_ptr;
  state_t             state;

  // The output register may refill in the same cycle it is emptied.
  assign load = !out_dv || out_rdy;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    mpa_road_fifo #(.WIDTH(ROAD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_dv[k]),
      .pop   (pop[k]),
      .din   (in_data[k*ROAD_W +: ROAD_W]),
      .dout  (dout[k]),
      .empty (empty[k]),
      .full  (full[k]),
      .count (count[k])
    );
    assign pop[k]       = load && !empty[k] && (grant == port_idx_t'(k));
    assign drop[k]      = in_dv[k] && full[k] && !pop[k];
    assign fifo_full[k] = (count[k] == CW'(FIFO_DEPTH));
  end

  // Scan downward so the port closest above rr_ptr is the last (winning) match.
  always_comb begin
    grant   = rr_ptr;
    any_req = 1'b0;
    idx     = rr_ptr;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = rr_ptr + port_idx_t'(i);
      if (!empty[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_port <= '0;
      out_dv   <= 1'b0;
      rr_ptr   <= '0;
    end else if (load) begin
      if (any_req) begin
        out_data <= dout[grant];
        out_port <= grant;
        out_dv   <= 1'b1;
        rr_ptr   <= grant + port_idx_t'(1);
      end else begin
        out_dv   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      ovf   <= '0;
    end else begin
      ovf <= ((state == DONE) ? 4'b0000 : ovf) | drop;
      case (state)
        RUN:     if (eor_in) state <= DRAIN;
        DRAIN:   if ((&empty) && !out_dv) state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

  assign eor_out = (state == DONE);
  assign busy    = (state == DRAIN);

`ifdef MPA_ARB_STATS_EN
  logic [15:0] cnt [N_PORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_PORTS; k++) cnt[k] <= '0;
    end else if (state == DONE) begin
      for (int k = 0; k < N_PORTS; k++) cnt[k] <= '0;
    end else if (out_dv && out_rdy && (cnt[out_port] != 16'hFFFF)) begin
      cnt[out_port] <= cnt[out_port] + 16'd1;
    end
  end

  for (genvar k = 0; k < N_PORTS; k++) begin : g_cnt
    assign word_cnt[k*16 +: 16] = cnt[k];
  end
`endif
endmodule

// File: tb/tb_mpa_road_arbiter.sv
// Randomized and directed bench for mpa_road_arbiter against a queue-based model.
module tb_mpa_road_arbiter;
  localparam int W     = 30;
  localparam int DEPTH = 8;
  localparam int MS_RUN = 0, MS_DRAIN = 1, MS_DONE = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [4*W-1:0] in_data = '0;
  logic [3:0]     in_dv = '0;
  logic           eor_in = 1'b0;
  logic [W-1:0]   out_data;
  logic [1:0]     out_port;
  logic           out_dv;
  logic           out_rdy = 1'b0;
  logic           eor_out;
  logic           busy;
  logic [3:0]     ovf;
  logic [3:0]     fifo_full;
`ifdef MPA_ARB_STATS_EN
  logic [63:0]    word_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int eor_cnt  = 0;
  int obs_port [$];
  logic [W-1:0] obs_data [$];

  logic [W-1:0] mq [4][$];
  logic         m_dv;
  logic [W-1:0] m_data;
  int           m_port;
  int           m_ptr;
  logic [3:0]   m_ovf;
  int           m_state;
  int           m_cnt [4];

  mpa_road_arbiter #(.ROAD_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_dv     (in_dv),
    .eor_in    (eor_in),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_dv    (out_dv),
    .out_rdy   (out_rdy),
    .eor_out   (eor_out),
    .busy      (busy),
    .ovf       (ovf),
    .fifo_full (fifo_full)
`ifdef MPA_ARB_STATS_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      m_cnt[k] = 0;
    end
    m_dv = 1'b0; m_data = '0; m_port = 0; m_ptr = 0; m_ovf = '0; m_state = MS_RUN;
  endtask

  // Advances the model by one clock edge given the inputs presented for that edge.
  task automatic model_step(input logic [3:0] dv, input logic [4*W-1:0] data,
                            input logic rdy, input logic eor);
    bit all_empty;
    bit found;
    int g;
    all_empty = !m_dv;
    for (int k = 0; k < 4; k++) if (mq[k].size() != 0) all_empty = 0;
    if (m_dv && rdy && m_cnt[m_port] < 65535) m_cnt[m_port]++;
    case (m_state)
      MS_RUN:   if (eor) m_state = MS_DRAIN;
      MS_DRAIN: if (all_empty) m_state = MS_DONE;
      default: begin
        m_state = MS_RUN;
        m_ovf   = '0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end
    endcase
    if (!m_dv || rdy) begin
      found = 0; g = 0;
      for (int i = 0; i < 4; i++)
        if (!found && mq[(m_ptr + i) % 4].size() != 0) begin
          found = 1; g = (m_ptr + i) % 4;
        end
      if (found) begin
        m_data = mq[g].pop_front();
        m_port = g;
        m_dv   = 1'b1;
        m_ptr  = (g + 1) % 4;
      end else begin
        m_dv = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++)
      if (dv[k]) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(data[k*W +: W]);
        else m_ovf[k] = 1'b1;
      end
  endtask

  task automatic tick(input logic [3:0] dv, input logic [4*W-1:0] data,
                      input logic rdy, input logic eor);
    in_dv = dv; in_data = data; out_rdy = rdy; eor_in = eor;
    if (out_dv && out_rdy) begin
      obs_port.push_back(int'(out_port));
      obs_data.push_back(out_data);
    end
    model_step(dv, data, rdy, eor);
    @(negedge clk);
    if (eor_out) eor_cnt++;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; in_dv = '0; in_data = '0; out_rdy = 1'b0; eor_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (out_dv !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_dv: got %b want 0", out_dv); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++; if (out_port !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_out_port: got %0d want 0", out_port); end
    n_checks++; if (eor_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_eor_out: got %b want 0", eor_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (ovf !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b want 0000", ovf); end
    n_checks++; if (fifo_full !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_fifo_full: got %b want 0000", fifo_full); end
  endtask

  task automatic test_single_word();
    logic [4*W-1:0] d;
    d = '0; d[W-1:0] = 30'h0ABCDEF;
    tick(4'b0001, d, 1'b1, 1'b0);
    n_checks++; if (out_dv !== 1'b0) begin n_fail++; $display("[TB] FAIL single_latency_early: out_dv %b want 0", out_dv); end
    tick(4'b0000, '0, 1'b1, 1'b0);
    n_checks++; if (out_dv !== 1'b1) begin n_fail++; $display("[TB] FAIL single_out_dv: got %b want 1", out_dv); end
    n_checks++; if (out_data !== 30'h0ABCDEF) begin n_fail++; $display("[TB] FAIL single_out_data: got %h want 0abcdef", out_data); end
    n_checks++; if (out_port !== 2'd0) begin n_fail++; $display("[TB] FAIL single_out_port: got %0d want 0", out_port); end
    tick(4'b0000, '0, 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [4*W-1:0] d;
    for (int k = 0; k < 4; k++) d[k*W +: W] = W'(k + 1);
    obs_port.delete(); obs_data.delete();
    tick(4'b1111, d, 1'b1, 1'b0);
    repeat (6) tick(4'b0000, '0, 1'b1, 1'b0);
    n_checks++; if (obs_port.size() != 4) begin n_fail++; $display("[TB] FAIL rr_count: got %0d words want 4", obs_port.size()); end
    for (int i = 0; i < 4 && i < obs_port.size(); i++) begin
      n_checks++;
      if (obs_port[i] != i || obs_data[i] !== W'(i + 1)) begin
        n_fail++;
        $display("[TB] FAIL rr_order[%0d]: got port %0d data %h want port %0d data %h", i, obs_port[i], obs_data[i], i, i + 1);
      end
    end
  endtask

  task automatic test_overflow();
    logic [4*W-1:0] d;
    int n2;
    d = '0; d[0 +: W] = 30'h111;
    tick(4'b0001, d, 1'b0, 1'b0);
    tick(4'b0000, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      d = '0; d[2*W +: W] = W'(32'h200 + i);
      tick(4'b0100, d, 1'b0, 1'b0);
      if (i == 7) begin
        n_checks++; if (fifo_full[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_full_after7: got %b want 0", fifo_full[2]); end
      end
      if (i == 8) begin
        n_checks++; if (fifo_full[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_full_after8: got %b want 1", fifo_full[2]); end
        n_checks++; if (ovf !== 4'b0000) begin n_fail++; $display("[TB] FAIL ovf_after8: got %b want 0000", ovf); end
      end
    end
    n_checks++; if (ovf !== 4'b0100) begin n_fail++; $display("[TB] FAIL ovf_after9: got %b want 0100", ovf); end
    obs_port.delete(); obs_data.delete();
    repeat (14) tick(4'b0000, '0, 1'b1, 1'b0);
    n_checks++; if (obs_port.size() < 1 || obs_port[0] != 0 || obs_data[0] !== 30'h111) begin
      n_fail++; $display("[TB] FAIL ovf_first_word: got %0d words want port0 data 111 first", obs_port.size());
    end
    n2 = 0;
    for (int i = 0; i < obs_port.size(); i++)
      if (obs_port[i] == 2) begin
        n2++;
        n_checks++;
        if (obs_data[i] !== W'(32'h200 + n2)) begin
          n_fail++; $display("[TB] FAIL ovf_word[%0d]: got %h want %h", n2, obs_data[i], 32'h200 + n2);
        end
      end
    n_checks++; if (n2 != 8) begin n_fail++; $display("[TB] FAIL ovf_release_count: got %0d want 8", n2); end
  endtask

  task automatic test_drain();
    logic [4*W-1:0] d;
    bit seen;
    eor_cnt = 0; seen = 0;
    obs_port.delete(); obs_data.delete();
    for (int i = 0; i < 3; i++) begin
      d = '0; d[W +: W] = W'(32'h300 + i);
      tick(4'b0010, d, (i % 2 == 0), 1'b0);
    end
    tick(4'b0000, '0, 1'b0, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_busy: got %b want 1", busy); end
    for (int i = 0; i < 30; i++) begin
      tick(4'b0000, '0, (i % 2 == 0), 1'b0);
      n_checks++; if (eor_out !== (m_state == MS_DONE)) begin n_fail++; $display("[TB] FAIL drain_eor_out[%0d]: got %b want %b", i, eor_out, m_state == MS_DONE); end
      if (eor_out && !seen) begin
        seen = 1;
        n_checks++; if (obs_port.size() != 3) begin n_fail++; $display("[TB] FAIL drain_eor_early: %0d transfers before eor_out want 3", obs_port.size()); end
      end
    end
    n_checks++; if (eor_cnt != 1) begin n_fail++; $display("[TB] FAIL drain_eor_pulses: got %0d want 1", eor_cnt); end
    n_checks++; if (ovf !== 4'b0000) begin n_fail++; $display("[TB] FAIL drain_ovf_clear: got %b want 0000", ovf); end
  endtask

  task automatic test_empty_eor();
    eor_cnt = 0;
    tick(4'b0000, '0, 1'b1, 1'b1);
    n_checks++; if (busy !== 1'b1 || eor_out !== 1'b0) begin n_fail++; $display("[TB] FAIL eor_empty_c1: busy %b eor_out %b want 1 0", busy, eor_out); end
    tick(4'b0000, '0, 1'b1, 1'b1);
    n_checks++; if (eor_out !== 1'b1) begin n_fail++; $display("[TB] FAIL eor_empty_c2: eor_out %b want 1", eor_out); end
    tick(4'b0000, '0, 1'b1, 1'b0);
    n_checks++; if (eor_out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL eor_empty_c3: eor_out %b busy %b want 0 0", eor_out, busy); end
    repeat (4) tick(4'b0000, '0, 1'b1, 1'b0);
    n_checks++; if (eor_cnt != 1) begin n_fail++; $display("[TB] FAIL eor_empty_pulses: got %0d want 1", eor_cnt); end
  endtask

  task automatic test_random();
    logic [4*W-1:0] d;
    logic [3:0] dv;
    logic [3:0] efull;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) d[k*W +: W] = W'($urandom);
      dv = (c % 100 < 50) ? 4'($urandom) : (4'($urandom) & 4'($urandom));
      tick(dv, d, ($urandom_range(0, 3) != 0) || (c % 100 >= 60), ($urandom_range(0, 39) == 0));
      for (int k = 0; k < 4; k++) efull[k] = (mq[k].size() == DEPTH);
      n_checks++;
      if (out_dv !== m_dv || out_data !== m_data || out_port !== 2'(m_port)) begin
        n_fail++; $display("[TB] FAIL rand_out[%0d]: got dv %b port %0d data %h want dv %b port %0d data %h",
                           c, out_dv, out_port, out_data, m_dv, m_port, m_data);
      end
      n_checks++;
      if (fifo_full !== efull || ovf !== m_ovf) begin
        n_fail++; $display("[TB] FAIL rand_flags[%0d]: got full %b ovf %b want full %b ovf %b", c, fifo_full, ovf, efull, m_ovf);
      end
      n_checks++;
      if (busy !== (m_state == MS_DRAIN) || eor_out !== (m_state == MS_DONE)) begin
        n_fail++; $display("[TB] FAIL rand_fsm[%0d]: got busy %b eor_out %b want state %0d", c, busy, eor_out, m_state);
      end
    end
`ifdef MPA_ARB_STATS_EN
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (word_cnt[k*16 +: 16] !== 16'(m_cnt[k])) begin
        n_fail++; $display("[TB] FAIL rand_word_cnt[%0d]: got %0d want %0d", k, word_cnt[k*16 +: 16], m_cnt[k]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_drain();
    logic [4*W-1:0] d;
    repeat (12) tick(4'b0000, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d = '0; d[3*W +: W] = W'(32'h400 + i);
      tick(4'b1000, d, 1'b0, 1'b0);
    end
    tick(4'b0000, '0, 1'b0, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_busy: got %b want 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (out_dv !== 1'b0 || out_data !== '0 || out_port !== 2'd0) begin
      n_fail++; $display("[TB] FAIL mid_reset_out: dv %b data %h port %0d want 0 0 0", out_dv, out_data, out_port);
    end
    n_checks++; if (busy !== 1'b0 || eor_out !== 1'b0 || ovf !== 4'b0 || fifo_full !== 4'b0) begin
      n_fail++; $display("[TB] FAIL mid_reset_flags: busy %b eor %b ovf %b full %b want all 0", busy, eor_out, ovf, fifo_full);
    end
`ifdef MPA_ARB_STATS_EN
    n_checks++; if (word_cnt !== '0) begin n_fail++; $display("[TB] FAIL mid_reset_word_cnt: got %h want 0", word_cnt); end
`endif
    model_reset();
    in_dv = '0; eor_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    eor_cnt = 0;
    repeat (6) tick(4'b0000, '0, 1'b1, 1'b0);
    n_checks++; if (eor_cnt != 0 || out_dv !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mid_reset_after: eor pulses %0d out_dv %b want 0 0", eor_cnt, out_dv);
    end
  endtask

  initial begin
    reset_dut();
    test_reset();
    test_single_word();
    reset_dut();
    test_round_robin();
    reset_dut();
    test_overflow();
    test_drain();
    test_empty_eor();
    test_random();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
